spi_apb_master_bridge: RTL

//  APB requester for the SPI controller's APB register file. Converts a simple command

---
 rtl/spi_apb_pkg.sv | 19 +
 rtl/spi_apb_wdog.sv | 43 ++++
 rtl/spi_apb_master_bridge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_apb_pkg.sv
// Package: spi_apb_pkg
// Purpose: Definitions shared by the SPI controller APB requester and the APB slave.
//   - apb_state_t : APB transfer phase (IDLE / SETUP / ACCESS)
//   - ADDR_*      : register map of the SPI controller APB register file
package spi_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

endpackage

// File: rtl/spi_apb_wdog.sv
// Module: spi_apb_wdog
// Purpose: Loadable saturating counter that bounds how long an APB ACCESS phase may
//   wait for PREADY.
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset
//   clear   in  load the count with zero (takes priority over enable)
//   enable  in  advance the count by one, saturating at TIMEOUT
//   expired out count has reached TIMEOUT-1, i.e. this is the last allowed wait cycle;
//               never asserted when TIMEOUT = 0
module spi_apb_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero TIMEOUT disables the watchdog; keep the counter one bit wide in that case.
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? CW'(0) : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter: cleared on load, saturates so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && (cnt_r != SAT)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (TIMEOUT == 0) ? 1'b0 : (cnt_r >= LAST);

endmodule

// File: rtl/spi_apb_master_bridge.sv
// Module: spi_apb_master_bridge
// Purpose: APB requester for the SPI controller register file. Turns a valid/ready
//   command into a two-phase APB transfer (SETUP, ACCESS) honouring PREADY wait states,
//   and reports read data, slave error and timeout as a one-cycle response pulse.
//   One transfer in flight; a command presented while the current ACCESS completes is
//   chained straight into a new SETUP without returning to IDLE.
// Ports:
//   PCLK, PRESET_n                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o      command handshake (ready is combinational)
//   cmd_write_i, cmd_addr_i, cmd_wdata_i   command payload
//   rsp_valid_o                    one-cycle response pulse, no backpressure
//   rsp_rdata_o, rsp_err_o, rsp_timeout_o  response fields, held between pulses
//   busy_o                         a transfer is in progress
//   PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o   APB requester outputs (registered)
//   PREADY_i, PSLVERR_i, PRDATA_i  APB completer inputs
module spi_apb_master_bridge
  import spi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output logic              PSEL_o,
  output logic              PENABLE_o,
  output logic              PWRITE_o,
  output logic [ADDR_W-1:0] PADDR_o,
  output logic [DATA_W-1:0] PWDATA_o,
  input  logic              PREADY_i,
  input  logic              PSLVERR_i,
  input  logic [DATA_W-1:0] PRDATA_i
);

  apb_state_t state_r;
  apb_state_t state_s;
  logic       idle_ready_r;
  logic       accept_s;
  logic       done_s;
  logic       tmo_s;
  logic       wdog_expired_s;

  // idle_ready_r is low during reset and the first cycle after it, so no command is
  // accepted while PRESET_n is asserted even though the state reads IDLE.
  assign done_s      = (state_r == ST_ACCESS) && PREADY_i;
  assign tmo_s       = (state_r == ST_ACCESS) && !PREADY_i && wdog_expired_s;
  assign cmd_ready_o = idle_ready_r || done_s;
  assign accept_s    = cmd_valid_i && cmd_ready_o;

  spi_apb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (PCLK),
    .rst_n   (PRESET_n),
    .clear   (state_r == ST_SETUP),
    .enable  ((state_r == ST_ACCESS) && !PREADY_i),
    .expired (wdog_expired_s)
  );

  // Next-state logic; PREADY wins over a simultaneous timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_SETUP;
        else          state_s = ST_IDLE;
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY_i) begin
          if (cmd_valid_i) state_s = ST_SETUP;
          else             state_s = ST_IDLE;
        end else if (wdog_expired_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and the phase-derived APB control outputs.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_r      <= ST_IDLE;
      idle_ready_r <= 1'b0;
      busy_o       <= 1'b0;
      PSEL_o       <= 1'b0;
      PENABLE_o    <= 1'b0;
    end else begin
      state_r      <= state_s;
      idle_ready_r <= (state_s == ST_IDLE);
      busy_o       <= (state_s != ST_IDLE);
      PSEL_o       <= (state_s != ST_IDLE);
      PENABLE_o    <= (state_s == ST_ACCESS);
    end
  end

  // Command payload capture; held unchanged from SETUP to the end of ACCESS and in IDLE.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      PWRITE_o <= 1'b0;
      PADDR_o  <= '0;
      PWDATA_o <= '0;
    end else if (accept_s) begin
      PWRITE_o <= cmd_write_i;
      PADDR_o  <= cmd_addr_i;
      PWDATA_o <= cmd_wdata_i;
    end else begin
      PWRITE_o <= PWRITE_o;
      PADDR_o  <= PADDR_o;
      PWDATA_o <= PWDATA_o;
    end
  end

  // Response register: uses the outgoing transfer's PWRITE_o, which a chained command
  // overwrites on this same edge.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else if (done_s) begin
      rsp_valid_o   <= 1'b1;
      rsp_rdata_o   <= (!PWRITE_o && !PSLVERR_i) ? PRDATA_i : '0;
      rsp_err_o     <= PSLVERR_i;
      rsp_timeout_o <= 1'b0;
    end else if (tmo_s) begin
      rsp_valid_o   <= 1'b1;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b1;
      rsp_timeout_o <= 1'b1;
    end else begin
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= rsp_rdata_o;
      rsp_err_o     <= rsp_err_o;
      rsp_timeout_o <= rsp_timeout_o;
    end
  end

endmodule
